// File: rtl/dot_unit.sv
// dot_unit - two-stage dot-product engine for the SIMD datapath.
//
// Stage 1 reduces the per-lane PE products with an adder tree and registers
// the lane sum together with the decoder command. Stage 2 applies that
// command one cycle later:
//   accumulate: acc <= acc + sum
//   shift:      res[0] <= acc + sum, res[i] <= res[i-1], acc <= 0
//   clear:      acc, res and ovf all return to zero
//
// Ports:
//   clk       clock
//   rstn      synchronous active-low reset; flushes any pending command
//   step      instruction-advance strobe; commands are sampled only when high
//   stall     freezes every register in the block
//   dot_ctrl  command: 00 none, 01 shift, 10 accumulate, 11 clear
//   prod_in   LANES products, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dot_out   result vector res[0..LANES-1], packed like prod_in
//   acc_out   current accumulator
//   busy      stage 1 holds a command not yet applied by stage 2
//   ovf       sticky signed overflow of the stage-2 add
module dot_unit #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          step,
  input  logic                          stall,
  input  logic [1:0]                    dot_ctrl,
  input  logic [LANES*DATA_WIDTH-1:0]   prod_in,
  output logic [LANES*DATA_WIDTH-1:0]   dot_out,
  output logic [DATA_WIDTH-1:0]         acc_out,
  output logic                          busy,
  output logic                          ovf
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_ACC   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;
  localparam int         MSB      = DATA_WIDTH - 1;

  // Lane unpacking
  logic [DATA_WIDTH-1:0] lane_val [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_val[gi] = prod_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Adder tree: pairwise reduction in place, halving the live width each
  // level. Sums wrap modulo 2^DATA_WIDTH; tree overflow is deliberately
  // not flagged.
  logic [DATA_WIDTH-1:0] tree_node [LANES];
  logic [DATA_WIDTH-1:0] lane_sum;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      tree_node[i] = lane_val[i];
    end
    for (int w = LANES / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        tree_node[j] = tree_node[2*j] + tree_node[2*j+1];
      end
    end
    lane_sum = tree_node[0];
  end

  // Pipeline state
  logic                  s1_v_reg,   s1_v_next;
  logic [1:0]            s1_op_reg,  s1_op_next;
  logic [DATA_WIDTH-1:0] s1_sum_reg, s1_sum_next;
  logic [DATA_WIDTH-1:0] acc_reg,    acc_next;
  logic                  ovf_reg,    ovf_next;
  logic [DATA_WIDTH-1:0] res_reg  [LANES];
  logic [DATA_WIDTH-1:0] res_next [LANES];

  // Stage-2 adder shared by accumulate and shift. Signed overflow: both
  // operands share a sign and the result's sign differs from it.
  logic [DATA_WIDTH-1:0] stage2_sum;
  logic                  stage2_ovf;

  assign stage2_sum = acc_reg + s1_sum_reg;
  assign stage2_ovf = (acc_reg[MSB] == s1_sum_reg[MSB]) &&
                      (stage2_sum[MSB] != acc_reg[MSB]);

  always_comb begin
    s1_v_next   = s1_v_reg;
    s1_op_next  = s1_op_reg;
    s1_sum_next = s1_sum_reg;
    acc_next    = acc_reg;
    ovf_next    = ovf_reg;
    for (int i = 0; i < LANES; i++) begin
      res_next[i] = res_reg[i];
    end

    if (!stall) begin
      // Stage 2 retires the pending command; a newly accepted command
      // below overrides the valid clear on the same edge.
      if (s1_v_reg) begin
        s1_v_next = 1'b0;
        case (s1_op_reg)
          OP_ACC: begin
            acc_next = stage2_sum;
            ovf_next = ovf_reg | stage2_ovf;
          end
          OP_SHIFT: begin
            res_next[0] = stage2_sum;
            for (int i = 1; i < LANES; i++) begin
              res_next[i] = res_reg[i-1];
            end
            acc_next = '0;
            ovf_next = ovf_reg | stage2_ovf;
          end
          OP_CLR: begin
            acc_next = '0;
            ovf_next = 1'b0;
            for (int i = 0; i < LANES; i++) begin
              res_next[i] = '0;
            end
          end
          default: begin
          end
        endcase
      end

      // Stage 1 samples a new command on every step.
      if (step) begin
        if (dot_ctrl != OP_NONE) begin
          s1_v_next   = 1'b1;
          s1_op_next  = dot_ctrl;
          s1_sum_next = lane_sum;
        end else begin
          s1_v_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_v_reg   <= 1'b0;
      s1_op_reg  <= OP_NONE;
      s1_sum_reg <= '0;
      acc_reg    <= '0;
      ovf_reg    <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        res_reg[i] <= '0;
      end
    end else begin
      s1_v_reg   <= s1_v_next;
      s1_op_reg  <= s1_op_next;
      s1_sum_reg <= s1_sum_next;
      acc_reg    <= acc_next;
      ovf_reg    <= ovf_next;
      for (int i = 0; i < LANES; i++) begin
        res_reg[i] <= res_next[i];
      end
    end
  end

  // Outputs come straight from registers.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_out
      assign dot_out[gi*DATA_WIDTH +: DATA_WIDTH] = res_reg[gi];
    end
  endgenerate

  assign acc_out = acc_reg;
  assign ovf     = ovf_reg;
  assign busy    = s1_v_reg;

endmodule

// File: tb/tb_dot_unit.sv
// Self-checking bench for dot_unit: directed scenarios plus a randomized run
// compared against a transaction-level model (command queue + arithmetic).
module tb_dot_unit;

  localparam int LANES = 4;
  localparam int DW    = 32;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  step;
  logic                  stall;
  logic [1:0]            dot_ctrl;
  logic [LANES*DW-1:0]   prod_in;
  logic [LANES*DW-1:0]   dot_out;
  logic [DW-1:0]         acc_out;
  logic                  busy;
  logic                  ovf;

  int checks = 0;
  int errors = 0;

  dot_unit #(.LANES(LANES), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .step(step), .stall(stall), .dot_ctrl(dot_ctrl),
    .prod_in(prod_in), .dot_out(dot_out), .acc_out(acc_out), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pending commands wait in a queue; each unstalled edge applies the oldest
  // one, then enqueues anything accepted on that edge.
  bit [DW-1:0] m_acc;
  bit [DW-1:0] m_res [LANES];
  bit          m_ovf;
  bit [DW+1:0] m_q [$];   // {op, sum}

  function automatic bit [DW-1:0] model_lane_sum(input logic [LANES*DW-1:0] p);
    longint total = 0;
    for (int i = 0; i < LANES; i++) total += longint'(p[i*DW +: DW]);
    return total[DW-1:0];
  endfunction

  function automatic bit add_overflows(input bit [DW-1:0] a, input bit [DW-1:0] b);
    longint s = longint'($signed(a)) + longint'($signed(b));
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic model_edge();
    bit [DW+1:0] e;
    bit [DW-1:0] v;
    if (!rstn) begin
      m_acc = '0; m_ovf = 0; m_q.delete();
      for (int i = 0; i < LANES; i++) m_res[i] = '0;
      return;
    end
    if (stall) return;
    if (m_q.size() != 0) begin
      e = m_q.pop_front();
      v = e[DW-1:0];
      case (e[DW+1:DW])
        2'b10: begin
          m_ovf = m_ovf | add_overflows(m_acc, v);
          m_acc = m_acc + v;
        end
        2'b01: begin
          m_ovf = m_ovf | add_overflows(m_acc, v);
          for (int i = LANES-1; i > 0; i--) m_res[i] = m_res[i-1];
          m_res[0] = m_acc + v;
          m_acc = '0;
        end
        2'b11: begin
          m_acc = '0; m_ovf = 0;
          for (int i = 0; i < LANES; i++) m_res[i] = '0;
        end
        default: ;
      endcase
    end
    if (step && dot_ctrl != 2'b00) begin
      m_q.push_back({dot_ctrl, model_lane_sum(prod_in)});
      $display("txn: t=%0t op=%0d lane_sum=%h", $time, dot_ctrl, model_lane_sum(prod_in));
    end
  endtask

  function automatic logic [LANES*DW-1:0] model_dot();
    logic [LANES*DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = m_res[i];
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_prod(input int a, input int b, input int c, input int d);
    prod_in = {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endtask

  task automatic cmd(input logic [1:0] op);
    step = 1'b1; stall = 1'b0; dot_ctrl = op;
  endtask

  task automatic idle();
    step = 1'b0; stall = 1'b0; dot_ctrl = 2'b00; prod_in = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'($urandom); stall = 1'($urandom); dot_ctrl = 2'($urandom);
      prod_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    checks++;
    if (dot_out !== '0 || acc_out !== '0 || busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: dot_out=%h acc_out=%h busy=%b ovf=%b, expected all zero",
               dot_out, acc_out, busy, ovf);
    end
    rstn = 1'b1; step = 1'b0; dot_ctrl = 2'($urandom);
    tick();
    tick();
    checks++;
    if (dot_out !== '0 || acc_out !== '0 || busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: dot_out=%h acc_out=%h busy=%b ovf=%b, expected all zero",
               dot_out, acc_out, busy, ovf);
    end
  endtask

  task automatic test_acc_shift();
    cmd(2'b10); set_prod(1, 2, 3, 4);
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL acc_busy: busy=%b expected 1", busy);
    end
    idle();
    tick();
    checks++;
    if (acc_out !== 32'd10) begin
      errors++; $display("FAIL acc_value: acc_out=%0d expected 10", acc_out);
    end
    cmd(2'b01); set_prod(0, 0, 0, 0);
    tick();
    idle();
    tick();
    checks++;
    if (dot_out[DW-1:0] !== 32'd10 || acc_out !== 32'd0) begin
      errors++;
      $display("FAIL shift_value: lane0=%0d acc_out=%0d expected lane0=10 acc_out=0",
               dot_out[DW-1:0], acc_out);
    end
  endtask

  task automatic test_shift_chain();
    bit seen;
    cmd(2'b10); set_prod(1, 1, 1, 1); tick();
    cmd(2'b10); set_prod(2, 2, 2, 2); tick();
    cmd(2'b01); set_prod(5, 5, 5, 5); tick();
    cmd(2'b01); set_prod(1, 0, 0, 0); tick();
    checks++;
    if (dot_out[DW-1:0] !== 32'd32) begin
      errors++; $display("FAIL chain_lane0: lane0=%0d expected 32", dot_out[DW-1:0]);
    end
    cmd(2'b01); set_prod(0, 0, 0, 0); tick();
    checks++;
    if (dot_out[DW-1:0] !== 32'd1 || dot_out[2*DW-1:DW] !== 32'd32) begin
      errors++;
      $display("FAIL chain_lane1: lane0=%0d lane1=%0d expected 1 and 32",
               dot_out[DW-1:0], dot_out[2*DW-1:DW]);
    end
    // One shift already accepted above; three more, then drain.
    for (int i = 0; i < 3; i++) tick();
    idle();
    tick();
    seen = 0;
    for (int i = 0; i < LANES; i++) if (dot_out[i*DW +: DW] === 32'd32) seen = 1;
    checks++;
    if (seen) begin
      errors++; $display("FAIL chain_gone: dot_out=%h still holds 32", dot_out);
    end
    checks++;
    if (dot_out !== model_dot()) begin
      errors++; $display("FAIL chain_vector: dot_out=%h expected %h", dot_out, model_dot());
    end
  endtask

  task automatic test_stall();
    cmd(2'b11); tick(); idle(); tick();   // start from a clean accumulator
    cmd(2'b10); set_prod(3, 3, 3, 3);
    tick();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; step = 1'($urandom); dot_ctrl = 2'($urandom);
      prod_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if (acc_out !== 32'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: cycle=%0d acc_out=%0d busy=%b expected 0 and 1",
                 i, acc_out, busy);
      end
    end
    idle();
    tick();
    checks++;
    if (acc_out !== 32'd12 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: acc_out=%0d busy=%b expected 12 and 0", acc_out, busy);
    end
  endtask

  task automatic test_overflow_clear();
    cmd(2'b11); tick();
    cmd(2'b10); set_prod(32'h7FFFFFFF, 0, 0, 0); tick();
    cmd(2'b10); set_prod(1, 0, 0, 0); tick();
    idle(); tick();
    checks++;
    if (acc_out !== 32'h80000000 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: acc_out=%h ovf=%b expected 80000000 and 1", acc_out, ovf);
    end
    cmd(2'b11); set_prod(7, 7, 7, 7); tick();
    idle(); tick();
    checks++;
    if (acc_out !== '0 || dot_out !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear: acc_out=%h dot_out=%h ovf=%b expected all zero",
               acc_out, dot_out, ovf);
    end
  endtask

  task automatic test_reset_mid();
    cmd(2'b10); set_prod(9, 9, 9, 9);
    tick();
    idle(); rstn = 1'b0;
    tick();
    checks++;
    if (acc_out !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: acc_out=%0d busy=%b expected 0 and 0", acc_out, busy);
    end
    rstn = 1'b1;
    tick(); tick();
    checks++;
    if (acc_out !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: acc_out=%0d busy=%b expected 0 and 0", acc_out, busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rstn     = ($urandom_range(0, 59) != 0);
      step     = 1'($urandom);
      stall    = ($urandom_range(0, 4) == 0);
      dot_ctrl = 2'($urandom);
      for (int i = 0; i < LANES; i++)
        prod_in[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1000);
      tick();
      checks++;
      if (dot_out !== model_dot() || acc_out !== m_acc || ovf !== m_ovf ||
          busy !== (m_q.size() != 0)) begin
        errors++;
        $display("FAIL random[%0d]: dot_out=%h acc_out=%h ovf=%b busy=%b expected dot_out=%h acc_out=%h ovf=%b busy=%b",
                 n, dot_out, acc_out, ovf, busy, model_dot(), m_acc, m_ovf, m_q.size() != 0);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; step = 1'b0; stall = 1'b0; dot_ctrl = 2'b00; prod_in = '0;
    test_reset();
    test_acc_shift();
    test_shift_chain();
    test_stall();
    test_overflow_clear();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
